// File: rtl/dma_region_guard.sv
// dma_region_guard: registered DMA/IRQ execution monitor over NREG code
// regions; holds the core in reset for at least KILL_CYCLES after a violation.
//
// Ports:
//   clk, rst (async, active-high)
//   pc           current program counter
//   dma_en       per-channel DMA access strobes (NCH)
//   dma_addr     packed per-channel DMA addresses (16*NCH)
//   irq          interrupt taken by the core
//   clr_cause    clears viol_cause/viol_region (honoured only in RUN)
//   reset        kill/reset to the core, high while in KILL
//   viol_cause   sticky {edge, irq, dma-into-region, dma-during-exec}
//   viol_region  sticky per-region hit bits
//
// Optional feature: define DMA_REGION_GUARD_IRQ_EN to enable the irq term.
module dma_region_guard #(
  parameter int                NREG          = 2,
  parameter int                NCH           = 2,
  parameter logic [16*NREG-1:0] REGION_BASE  = {16'hA000, 16'hE000},
  parameter logic [16*NREG-1:0] REGION_SIZE  = {16'h4000, 16'h1000},
  parameter logic [15:0]       RESET_HANDLER = 16'h0000,
  parameter int                KILL_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  input  logic [NCH-1:0]    dma_en,
  input  logic [16*NCH-1:0] dma_addr,
  input  logic              irq,
  input  logic              clr_cause,
  output logic              reset,
  output logic [3:0]        viol_cause,
  output logic [NREG-1:0]   viol_region
);

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

  localparam logic [7:0] KILL_LOAD = 8'(KILL_CYCLES - 1);

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [15:0]    prev_pc;
  logic [NREG-1:0] in_pc, in_prev;
  logic [NREG-1:0] exec_hit, dma_hit, irq_hit, edge_hit;
  logic [3:0]     cause_new;
  logic [NREG-1:0] region_new;
  logic           viol;

  function automatic logic [15:0] base_of(input int r);
    return REGION_BASE[16*r +: 16];
  endfunction

  function automatic logic [15:0] last_of(input int r);
    return REGION_BASE[16*r +: 16] + REGION_SIZE[16*r +: 16] - 16'd2;
  endfunction

  function automatic logic in_rgn(input int r, input logic [15:0] a);
    return (a >= base_of(r)) && (a <= last_of(r));
  endfunction

`ifndef DMA_REGION_GUARD_IRQ_EN
  logic unused_irq;
  assign unused_irq = irq;
`endif

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      in_pc[r]    = in_rgn(r, pc);
      in_prev[r]  = in_rgn(r, prev_pc);
      exec_hit[r] = in_pc[r] & (|dma_en);
      dma_hit[r]  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (dma_en[c] && in_rgn(r, dma_addr[16*c +: 16]))
          dma_hit[r] = 1'b1;
      end
`ifdef DMA_REGION_GUARD_IRQ_EN
      irq_hit[r]  = in_pc[r] & irq;
`else
      irq_hit[r]  = 1'b0;
`endif
      // Entry must land on the first word, exit must leave from the last.
      edge_hit[r] = (!in_prev[r] && in_pc[r] && pc != base_of(r)) ||
                    (in_prev[r] && !in_pc[r] && prev_pc != last_of(r));
    end
    cause_new  = {|edge_hit, |irq_hit, |dma_hit, |exec_hit};
    region_new = exec_hit | dma_hit | irq_hit | edge_hit;
    viol       = |cause_new;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (viol) begin
          state_d = KILL;
          cnt_d   = KILL_LOAD;
        end
      end
      KILL: begin
        // A fresh violation beats release and restarts the hold time.
        if (viol) begin
          cnt_d = KILL_LOAD;
        end else if (cnt_q == 8'd0 && pc == RESET_HANDLER) begin
          state_d = RUN;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = KILL;
        cnt_d   = KILL_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= KILL;
      cnt_q   <= KILL_LOAD;
      prev_pc <= RESET_HANDLER;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_pc <= pc;
    end
  end

  // New violation bits are ORed in after a clear, so they win over it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_cause  <= '0;
      viol_region <= '0;
    end else if (state_q == RUN && clr_cause) begin
      viol_cause  <= cause_new;
      viol_region <= region_new;
    end else begin
      viol_cause  <= viol_cause | cause_new;
      viol_region <= viol_region | region_new;
    end
  end

  assign reset = (state_q == KILL);

endmodule

// File: tb/tb_dma_region_guard.sv
// tb_dma_region_guard: directed vectors for dma_region_guard; expected
// outputs are queued by the stimulus and checked by a separate monitor.
module tb_dma_region_guard;

`ifdef DMA_REGION_GUARD_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct packed {
    logic       rst_v;
    logic [3:0] cause;
    logic [1:0] region;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic [1:0]  dma_en = 2'b00;
  logic [31:0] dma_addr = 32'h0;
  logic        irq = 1'b0;
  logic        clr_cause = 1'b0;
  logic        reset;
  logic [3:0]  viol_cause;
  logic [1:0]  viol_region;

  exp_t q[$];
  int   applied = 0;
  int   miscompares = 0;
  int   vec_id = 0;

  // Region 0 = A000..DFFE, region 1 = E000..EFFE.
  dma_region_guard #(
    .NREG(2), .NCH(2),
    .REGION_BASE({16'hE000, 16'hA000}),
    .REGION_SIZE({16'h1000, 16'h4000}),
    .RESET_HANDLER(16'h0000),
    .KILL_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .dma_en(dma_en),
    .dma_addr(dma_addr), .irq(irq), .clr_cause(clr_cause),
    .reset(reset), .viol_cause(viol_cause), .viol_region(viol_region)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input exp_t e);
    applied++;
    if (reset !== e.rst_v || viol_cause !== e.cause ||
        viol_region !== e.region) begin
      miscompares++;
      $display("FAIL %s: got reset=%b cause=%b region=%b, want reset=%b cause=%b region=%b",
               name, reset, viol_cause, viol_region,
               e.rst_v, e.cause, e.region);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vec_id++;
        compare($sformatf("vec%0d", vec_id), e);
      end
    end
  end

  task automatic step(input logic r, input logic [15:0] p,
                      input logic [1:0] en, input logic [15:0] a0,
                      input logic [15:0] a1, input logic iq,
                      input logic clr, input logic er,
                      input logic [3:0] ec, input logic [1:0] eg);
    exp_t e;
    @(negedge clk);
    rst = r; pc = p; dma_en = en;
    dma_addr = {a1, a0}; irq = iq; clr_cause = clr;
    e.rst_v = er; e.cause = ec; e.region = eg;
    q.push_back(e);
  endtask

  task automatic idle(input logic [15:0] p, input logic er,
                      input logic [3:0] ec, input logic [1:0] eg);
    step(1'b0, p, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, er, ec, eg);
  endtask

  task automatic clr(input logic er, input logic [3:0] ec,
                     input logic [1:0] eg);
    step(1'b0, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, er, ec, eg);
  endtask

  initial begin : stim
    exp_t e;
    // Release from reset: high for four edges after rst drops.
    step(1, 16'h0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00);
    idle(16'h0, 1, 4'b0000, 2'b00);
    idle(16'h0, 1, 4'b0000, 2'b00);
    idle(16'h0, 1, 4'b0000, 2'b00);
    idle(16'h0, 0, 4'b0000, 2'b00);
    idle(16'h0, 0, 4'b0000, 2'b00);

    // DMA during region execution.
    idle(16'hA000, 0, 4'b0000, 2'b00);
    step(0, 16'hA002, 2'b01, 16'h1000, 0, 0, 0, 1, 4'b0001, 2'b01);
    idle(16'hDFFE, 1, 4'b0001, 2'b01);
    idle(16'h0000, 1, 4'b0001, 2'b01);
    idle(16'h0000, 1, 4'b0001, 2'b01);
    idle(16'h0000, 0, 4'b0001, 2'b01);
    clr(0, 4'b0000, 2'b00);

    // DMA into region 1; clr_cause ignored while in KILL.
    step(0, 16'h4000, 2'b10, 0, 16'hE100, 0, 0, 1, 4'b0010, 2'b10);
    step(0, 16'h4000, 2'b00, 0, 0, 0, 1, 1, 4'b0010, 2'b10);
    idle(16'h0000, 1, 4'b0010, 2'b10);
    idle(16'h0000, 1, 4'b0010, 2'b10);
    idle(16'h0000, 0, 4'b0010, 2'b10);
    clr(0, 4'b0000, 2'b00);

    // Clear and violation together: new bits win.
    step(0, 16'h0, 2'b10, 0, 16'hE000, 0, 1, 1, 4'b0010, 2'b10);
    idle(16'h0000, 1, 4'b0010, 2'b10);
    idle(16'h0000, 1, 4'b0010, 2'b10);
    idle(16'h0000, 1, 4'b0010, 2'b10);
    idle(16'h0000, 0, 4'b0010, 2'b10);
    clr(0, 4'b0000, 2'b00);

    // Illegal entry.
    idle(16'h4000, 0, 4'b0000, 2'b00);
    idle(16'hA010, 1, 4'b1000, 2'b01);
    idle(16'hDFFE, 1, 4'b1000, 2'b01);
    idle(16'h0000, 1, 4'b1000, 2'b01);
    idle(16'h0000, 1, 4'b1000, 2'b01);
    idle(16'h0000, 0, 4'b1000, 2'b01);
    clr(0, 4'b0000, 2'b00);

    // Legal entry, jump to last word, legal exit.
    idle(16'hA000, 0, 4'b0000, 2'b00);
    idle(16'hDFFE, 0, 4'b0000, 2'b00);
    idle(16'h4000, 0, 4'b0000, 2'b00);

    // Illegal exit.
    idle(16'hA000, 0, 4'b0000, 2'b00);
    idle(16'hA010, 0, 4'b0000, 2'b00);
    idle(16'h4000, 1, 4'b1000, 2'b01);
    idle(16'h0000, 1, 4'b1000, 2'b01);
    idle(16'h0000, 1, 4'b1000, 2'b01);
    idle(16'h0000, 1, 4'b1000, 2'b01);
    idle(16'h0000, 0, 4'b1000, 2'b01);
    clr(0, 4'b0000, 2'b00);

    // IRQ inside a region: fires only with the irq guard built in.
    idle(16'hA000, 0, 4'b0000, 2'b00);
    step(0, 16'hA004, 0, 0, 0, 1, 0, IRQ_ON,
         IRQ_ON ? 4'b0100 : 4'b0000, IRQ_ON ? 2'b01 : 2'b00);
    idle(16'hDFFE, IRQ_ON, IRQ_ON ? 4'b0100 : 4'b0000,
         IRQ_ON ? 2'b01 : 2'b00);
    idle(16'h0000, IRQ_ON, IRQ_ON ? 4'b0100 : 4'b0000,
         IRQ_ON ? 2'b01 : 2'b00);
    idle(16'h0000, IRQ_ON, IRQ_ON ? 4'b0100 : 4'b0000,
         IRQ_ON ? 2'b01 : 2'b00);
    idle(16'h0000, 0, IRQ_ON ? 4'b0100 : 4'b0000,
         IRQ_ON ? 2'b01 : 2'b00);
    clr(0, 4'b0000, 2'b00);

    // Two channels into both regions, then violation at release point.
    step(0, 16'h0, 2'b11, 16'hA000, 16'hE000, 0, 0, 1, 4'b0010, 2'b11);
    idle(16'h0000, 1, 4'b0010, 2'b11);
    idle(16'h0000, 1, 4'b0010, 2'b11);
    idle(16'h0000, 1, 4'b0010, 2'b11);
    step(0, 16'h0, 2'b01, 16'hA000, 0, 0, 0, 1, 4'b0010, 2'b11);
    clr(1, 4'b0010, 2'b11);
    idle(16'h0000, 1, 4'b0010, 2'b11);
    idle(16'h0000, 1, 4'b0010, 2'b11);
    idle(16'h0000, 0, 4'b0010, 2'b11);
    clr(0, 4'b0000, 2'b00);

    // Async reset mid-operation.
    step(0, 16'h0, 2'b01, 16'hA100, 0, 0, 0, 1, 4'b0010, 2'b01);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    e.rst_v = 1'b1; e.cause = 4'b0000; e.region = 2'b00;
    compare("async_rst", e);
    step(1, 16'h0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00);
    idle(16'h0000, 1, 4'b0000, 2'b00);
    idle(16'h0000, 1, 4'b0000, 2'b00);
    idle(16'h0000, 1, 4'b0000, 2'b00);
    idle(16'h0000, 0, 4'b0000, 2'b00);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
